branch_predictor_btb: RTL and testbench
=======================================

Name: branch_predictor_btb

Overview:
Parametrised branch target buffer with a saturating-counter direction predictor. It is looked up in IF with the fetch PC and updated from the branch-resolution stage. It replaces the fixed "always fall through, redirect at MEM" policy with speculative redirection in IF. The block also flags mispredictions and supplies the recovery PC, so the pipeline control can flush the wrong-path instructions.

Parameters:
XLEN, 32, address/data width
ENTRIES, 16, BTB entries; power of two, >= 2
CTR_W, 2, direction counter width; >= 1
CNT_W, 16, statistics counter width

Ports:
clk  input  1  clock; all state updates on rising edge
rst_b  input  1  asynchronous, active-high reset (asserted = 1)
lookup_pc  input  XLEN  fetch PC (IF)
pred_hit  output  1  tag hit for lookup_pc
pred_taken  output  1  predicted taken
pred_target  output  XLEN  predicted next PC
upd_valid  input  1  a resolved control instruction is presented this cycle
upd_pc  input  XLEN  PC of the resolved instruction
upd_taken  input  1  actual direction
upd_target  input  XLEN  actual taken target
upd_pred_taken  input  1  prediction made in IF, carried down the pipe
upd_pred_target  input  XLEN  predicted target, carried down the pipe
bt_flush  input  1  synchronous invalidate of all entries
mispredict  output  1  redirect required
recover_pc  output  XLEN  correct next PC when mispredict = 1
upd_cnt  output  CNT_W  number of accepted updates
mispred_cnt  output  CNT_W  number of mispredictions

Behaviour:
- IDX_W = log2(ENTRIES). Index = pc[IDX_W+1:2]. Tag = pc[XLEN-1:IDX_W+2]. pc[1:0] is ignored.
- Per entry: valid, tag, target, ctr[CTR_W-1:0].
- Constants: WNT = 2^(CTR_W-1)-1, WT = 2^(CTR_W-1), MAX = 2^CTR_W-1.
- Reset (async): all valid=0, all ctr=WNT, upd_cnt=0, mispred_cnt=0.
- Outputs under reset follow from that state: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
- Lookup is combinational with 0-cycle latency:
  - pred_hit = valid && tag match.
  - pred_taken = pred_hit && ctr[MSB].
  - pred_target = pred_taken ? target : lookup_pc+4, computed mod 2^XLEN (wraps).
- Resolution is combinational:
  - mispredict = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)).
  - recover_pc = upd_taken ? upd_target : upd_pc+4. It is only meaningful while mispredict=1.
- Update at the rising edge when upd_valid=1 and bt_flush=0:
  - Hit, taken: ctr = min(ctr+1, MAX); target = upd_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss (invalid entry, or valid with a different tag), taken: allocate and overwrite. valid=1, tag and target written, ctr=WT.
  - Miss, not taken: no change.
- Statistics:
  - upd_cnt increments on every upd_valid.
  - mispred_cnt increments on every mispredict.
  - Both saturate at all-ones; they do not wrap.
  - Both count even when bt_flush=1.
- bt_flush=1 clears every valid bit at the edge, and ctr resets to WNT. It has priority over a same-cycle update, and that update is dropped.
- A lookup and an update to the same entry in the same cycle: the lookup sees pre-update contents. There is no bypass.
- Reset asserted mid-operation clears the state immediately, without waiting for clk.

Decomposition:
- Package branch_pred_pkg holds:
  - functions idx_of(pc), tag_of(pc), parametrised by ENTRIES/XLEN;
  - counter constants WNT/WT/MAX as functions of CTR_W.
- One sub-module, sat_counter (CTR_W-bit up/down saturating counter with load). It is instantiated per entry or used as the next-state function.

Test Plan:
1. Reset, then lookup_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x44. upd_cnt=0, mispred_cnt=0.
2. Update upd_pc=0x40, taken, target=0x100, pred_taken=0 -> same cycle mispredict=1, recover_pc=0x100. Next cycle, lookup 0x40 gives hit=1, taken=1, target=0x100, and mispred_cnt=1.
3. From state 2, three not-taken updates to 0x40 -> ctr goes 2→1→0→0 (saturates). After the first, lookup gives taken=0, target=0x44. Each update has pred_taken matching the current ctr MSB, so only the first raises mispredict.
4. Alias: lookup 0x80 (same index 0, tag 2) after state 2 -> hit=0. A taken update at 0x80 with target 0x200 evicts it. Lookup 0x40 then misses; 0x80 hits with target 0x200.
5. Same cycle: update 0x40 taken while looking up 0x40 from reset -> lookup shows hit=0, and the entry is valid the next cycle. A later bt_flush=1 together with an update -> all entries invalid next cycle, and upd_cnt still increments.
6. Assert rst_b between clock edges with valid entries and counters nonzero -> outputs return to reset values before the next edge. Drive mispred_cnt to 0xFFFF (CNT_W=16) and force another mispredict -> it stays 0xFFFF.

Source files
------------

// File: rtl/branch_pred_pkg.sv
// Shared helpers for the branch target buffer.
// Index/tag extraction and direction counter constants.
package branch_pred_pkg;

  function automatic logic [63:0] idx_of(
    input logic [63:0] pc,
    input int          idx_w
  );
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] tag_of(
    input logic [63:0] pc,
    input int          idx_w
  );
    return pc >> (idx_w + 2);
  endfunction

  function automatic int ctr_wnt(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int ctr_wt(input int w);
    return 1 << (w - 1);
  endfunction

  function automatic int ctr_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/branch_predictor_btb_sat_counter.sv
// Next-state function of an up/down saturating counter with load.
// Load wins over inc/dec; inc and dec clamp at the rails.
module sat_counter #(
  parameter int W = 2
) (
  input  logic [W-1:0] ctr,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] nxt
);

  always_comb begin
    nxt = ctr;
    unique case (1'b1)
      load: nxt = load_val;
      inc:  nxt = (ctr == '1) ? ctr : ctr + 1'b1;
      dec:  nxt = (ctr == '0) ? ctr : ctr - 1'b1;
      default: nxt = ctr;
    endcase
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry saturating direction counters.
// Lookup in IF, update and misprediction detection at resolution.
module branch_predictor_btb
  import branch_pred_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [XLEN-1:0]  lookup_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             upd_valid,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_target,
  input  logic             upd_pred_taken,
  input  logic [XLEN-1:0]  upd_pred_target,
  input  logic             bt_flush,
  output logic             mispredict,
  output logic [XLEN-1:0]  recover_pc,
  output logic [CNT_W-1:0] upd_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CTR_W-1:0] WNT = CTR_W'(ctr_wnt(CTR_W));
  localparam logic [CTR_W-1:0] WT  = CTR_W'(ctr_wt(CTR_W));

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [XLEN-1:0]  tgt_q   [ENTRIES];
  logic [CTR_W-1:0] ctr_q   [ENTRIES];

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             u_hit, u_we;
  logic [CTR_W-1:0] ctr_nxt;

  assign l_idx = IDX_W'(idx_of(64'(lookup_pc), IDX_W));
  assign l_tag = TAG_W'(tag_of(64'(lookup_pc), IDX_W));
  assign u_idx = IDX_W'(idx_of(64'(upd_pc), IDX_W));
  assign u_tag = TAG_W'(tag_of(64'(upd_pc), IDX_W));

  assign pred_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign pred_taken  = pred_hit && ctr_q[l_idx][CTR_W-1];
  assign pred_target = pred_taken ? tgt_q[l_idx] : lookup_pc + XLEN'(4);

  assign mispredict = upd_valid &&
    ((upd_taken != upd_pred_taken) ||
     (upd_taken && (upd_target != upd_pred_target)));
  assign recover_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);

  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  // Not-taken misses never allocate, so the entry is left alone.
  assign u_we  = upd_valid && !bt_flush && (u_hit || upd_taken);

  sat_counter #(.W(CTR_W)) u_ctr (
    .ctr      (ctr_q[u_idx]),
    .inc      (u_hit && upd_taken),
    .dec      (u_hit && !upd_taken),
    .load     (!u_hit && upd_taken),
    .load_val (WT),
    .nxt      (ctr_nxt)
  );

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= WNT;
      end
    end else if (bt_flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= WNT;
      end
    end else if (u_we) begin
      valid_q[u_idx] <= 1'b1;
      ctr_q[u_idx]   <= ctr_nxt;
    end
  end

  // Tag and target are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (u_we && upd_taken) begin
      tag_q[u_idx] <= u_tag;
      tgt_q[u_idx] <= upd_target;
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      upd_cnt     <= '0;
      mispred_cnt <= '0;
    end else begin
      if (upd_valid && (upd_cnt != '1))
        upd_cnt <= upd_cnt + 1'b1;
      if (mispredict && (mispred_cnt != '1))
        mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed self-checking bench for branch_predictor_btb.
// Hand-computed expectations for lookup, update, flush and reset.
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] lookup_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        bt_flush;
  logic        mispredict;
  logic [31:0] recover_pc;
  logic [15:0] upd_cnt, mispred_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  branch_predictor_btb dut (
    .clk             (clk),
    .rst_b           (rst_b),
    .lookup_pc       (lookup_pc),
    .pred_hit        (pred_hit),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .bt_flush        (bt_flush),
    .mispredict      (mispredict),
    .recover_pc      (recover_pc),
    .upd_cnt         (upd_cnt),
    .mispred_cnt     (mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(
    input logic [31:0] pc,
    input logic        tk,
    input logic [31:0] tgt,
    input logic        ptk,
    input logic [31:0] ptgt
  );
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
    #1;
  endtask

  task automatic idle();
    upd_valid = 1'b0;
    bt_flush  = 1'b0;
  endtask

  task automatic look(
    input string       tag,
    input logic [31:0] pc,
    input logic        hit,
    input logic        tk,
    input logic [31:0] tgt
  );
    lookup_pc = pc;
    #1;
    chk({tag, ".hit"}, pred_hit, hit);
    chk({tag, ".taken"}, pred_taken, tk);
    chk({tag, ".target"}, pred_target, tgt);
  endtask

  initial begin
    rst_b = 1'b1;
    lookup_pc = 32'h40;
    idle();
    upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_pred_taken = 1'b0; upd_pred_target = '0;
    look("rst", 32'h40, 1'b0, 1'b0, 32'h44);
    chk("rst.upd_cnt", upd_cnt, 16'd0);
    chk("rst.mis_cnt", mispred_cnt, 16'd0);
    #1 rst_b = 1'b0;
    tick();

    // first taken update with concurrent lookup of same PC
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    chk("alloc.mis", mispredict, 1'b1);
    chk("alloc.rec", recover_pc, 32'h100);
    look("alloc.same", 32'h40, 1'b0, 1'b0, 32'h44);
    tick(); idle();
    look("alloc.next", 32'h40, 1'b1, 1'b1, 32'h100);
    chk("alloc.mis_cnt", mispred_cnt, 16'd1);

    // three not-taken updates: ctr 2->1->0->0
    upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
    chk("nt1.mis", mispredict, 1'b1);
    chk("nt1.rec", recover_pc, 32'h44);
    tick(); idle();
    look("nt1", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
    chk("nt2.mis", mispredict, 1'b0);
    tick();
    upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
    chk("nt3.mis", mispredict, 1'b0);
    tick(); idle();
    look("nt3", 32'h40, 1'b1, 1'b0, 32'h44);

    // from saturated 0 one taken step reaches 1, a second reaches 2
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    tick(); idle();
    look("tk1", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    tick(); idle();
    look("tk2", 32'h40, 1'b1, 1'b1, 32'h100);
    chk("tk2.upd_cnt", upd_cnt, 16'd6);
    chk("tk2.mis_cnt", mispred_cnt, 16'd4);

    // aliasing PC at index 0 with a different tag evicts 0x40
    look("alias.pre", 32'h80, 1'b0, 1'b0, 32'h84);
    upd(32'h80, 1'b1, 32'h200, 1'b0, 32'h84);
    tick(); idle();
    look("alias.old", 32'h40, 1'b0, 1'b0, 32'h44);
    look("alias.new", 32'h80, 1'b1, 1'b1, 32'h200);

    // correctly predicted allocation at index 1
    upd(32'h44, 1'b1, 32'h300, 1'b1, 32'h300);
    chk("idx1.mis", mispredict, 1'b0);
    tick(); idle();
    look("idx1", 32'h44, 1'b1, 1'b1, 32'h300);

    // not-taken miss allocates nothing
    upd(32'h48, 1'b0, 32'h0, 1'b0, 32'h4C);
    tick(); idle();
    look("ntmiss", 32'h48, 1'b0, 1'b0, 32'h4C);

    // right direction, wrong target
    upd(32'h80, 1'b1, 32'h204, 1'b1, 32'h200);
    chk("tgt.mis", mispredict, 1'b1);
    chk("tgt.rec", recover_pc, 32'h204);
    tick(); idle();
    look("tgt", 32'h80, 1'b1, 1'b1, 32'h204);
    chk("tgt.upd_cnt", upd_cnt, 16'd10);
    chk("tgt.mis_cnt", mispred_cnt, 16'd6);

    // flush beats a same-cycle update, stats still count
    upd(32'h48, 1'b1, 32'h500, 1'b0, 32'h4C);
    bt_flush = 1'b1;
    tick(); idle();
    look("fl.80", 32'h80, 1'b0, 1'b0, 32'h84);
    look("fl.44", 32'h44, 1'b0, 1'b0, 32'h48);
    look("fl.48", 32'h48, 1'b0, 1'b0, 32'h4C);
    chk("fl.upd_cnt", upd_cnt, 16'd11);
    chk("fl.mis_cnt", mispred_cnt, 16'd7);

    // fall-through wraps modulo 2^32
    look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    upd(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h10);
    chk("wrap.rec", recover_pc, 32'h0);
    tick(); idle();

    // asynchronous reset between edges
    upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    tick(); idle();
    look("prerst", 32'h40, 1'b1, 1'b1, 32'h100);
    rst_b = 1'b1;
    look("arst", 32'h40, 1'b0, 1'b0, 32'h44);
    chk("arst.upd_cnt", upd_cnt, 16'd0);
    chk("arst.mis_cnt", mispred_cnt, 16'd0);
    @(negedge clk);
    rst_b = 1'b0;
    tick();

    // statistics saturate at all-ones
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat.pre", mispred_cnt, 16'hFFFE);
    tick();
    chk("sat.mis_cnt", mispred_cnt, 16'hFFFF);
    chk("sat.upd_cnt", upd_cnt, 16'hFFFF);
    tick();
    chk("sat.hold_mis", mispred_cnt, 16'hFFFF);
    chk("sat.hold_upd", upd_cnt, 16'hFFFF);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
